dm_bank: RTL and testbench

- Parametrised successor to the PE data memory: a single-write, dual-read block-RAM bank that decodes read and write addresses from the PE instruction word.
- Adds the following over the previous generation:
  - Configurable width and depth.
  - Selectable read-during-write bypass.
  - Optional output pipeline register with a matching read-valid strobe.
  - A hardware clear sequencer that zeroes the array after reset or on request.
- Sits inside each PE between the instruction decoder and the ALU operand inputs.

---
 rtl/dm_bank.sv | 157 +++++++++++++++
 tb/tb_dm_bank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bank.sv
// dm_bank: single-write, dual-read PE data memory bank with read bypass,
// optional output register and a zeroing sweep after reset or clear.
module dm_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = 32,
    parameter int BYPASS     = 1,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wren,
    input  logic                  rden,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid,
    output logic                  ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] raddr0, raddr1, waddr;
    logic                  acc_wr, acc_rd, clearing;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram0_q, ram1_q;

    logic                  byp0_d, byp1_d;
    logic                  byp0_q, byp1_q;
    logic [DATA_WIDTH-1:0] wd_q;
    logic                  have_q, vld1_q;
    logic [DATA_WIDTH-1:0] s1_data0, s1_data1;

    assign raddr0 = inst[ADDR_WIDTH-1:0];
    assign raddr1 = inst[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign waddr  = inst[3*ADDR_WIDTH-1:2*ADDR_WIDTH];

    generate
        if (INST_WIDTH > 3*ADDR_WIDTH) begin : g_spare
            logic unused_inst;
            assign unused_inst = ^inst[INST_WIDTH-1:3*ADDR_WIDTH];
        end
    endgenerate

    assign clearing = (state_q == S_CLEAR);
    assign ready    = (state_q == S_READY);
    assign acc_wr   = ready & wren;
    assign acc_rd   = ready & rden;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}})
                    state_d = S_READY;
            end
            default: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sweep owns the single write port while clearing.
    assign mem_we = clearing | acc_wr;
    assign mem_wa = clearing ? cnt_q : waddr;
    assign mem_wd = clearing ? '0 : wdata;

    // Plain read-first array, no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
        if (acc_rd) begin
            ram0_q <= mem[raddr0];
            ram1_q <= mem[raddr1];
        end
    end

    assign byp0_d = (BYPASS != 0) && acc_wr && (waddr == raddr0);
    assign byp1_d = (BYPASS != 0) && acc_wr && (waddr == raddr1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byp0_q <= 1'b0;
            byp1_q <= 1'b0;
            wd_q   <= '0;
            have_q <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            vld1_q <= acc_rd;
            if (acc_rd) begin
                byp0_q <= byp0_d;
                byp1_q <= byp1_d;
                wd_q   <= wdata;
                have_q <= 1'b1;
            end
        end
    end

    // have_q masks the unreset RAM latches until the first real read.
    assign s1_data0 = !have_q ? '0 : (byp0_q ? wd_q : ram0_q);
    assign s1_data1 = !have_q ? '0 : (byp1_q ? wd_q : ram1_q);

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] out0_q, out1_q;
            logic                  vld2_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out0_q <= '0;
                    out1_q <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    vld2_q <= vld1_q;
                    if (vld1_q) begin
                        out0_q <= s1_data0;
                        out1_q <= s1_data1;
                    end
                end
            end
            assign rdata0 = out0_q;
            assign rdata1 = out1_q;
            assign rvalid = vld2_q;
        end else begin : g_noreg
            assign rdata0 = s1_data0;
            assign rdata1 = s1_data1;
            assign rvalid = vld1_q;
        end
    endgenerate

endmodule

// File: tb/tb_dm_bank.sv
// tb_dm_bank: directed checks of sweep, read/write, bypass, hold,
// clear request and reset during clear (ADDR_WIDTH=4, BYPASS=1, OUT_REG=0).
module tb_dm_bank;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        wren;
    logic        rden;
    logic [31:0] inst;
    logic [15:0] wdata;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic        rvalid;
    logic        ready;

    int n_tests;
    int n_fail;

    dm_bank #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4),
        .INST_WIDTH(32),
        .BYPASS    (1),
        .OUT_REG   (0)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .wren  (wren),
        .rden  (rden),
        .inst  (inst),
        .wdata (wdata),
        .rdata0(rdata0),
        .rdata1(rdata1),
        .rvalid(rvalid),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upper inst bits carry junk that the bank must ignore.
    function automatic logic [31:0] mk(input int w, input int a1,
                                       input int a0);
        logic [3:0] wv, a1v, a0v;
        wv  = w[3:0];
        a1v = a1[3:0];
        a0v = a0[3:0];
        return {20'hABCDE, wv, a1v, a0v};
    endfunction

    task automatic wr(input int a, input logic [15:0] d);
        wren  = 1'b1;
        inst  = mk(a, 0, 0);
        wdata = d;
        tick();
        wren  = 1'b0;
    endtask

    task automatic rd(input int a0, input int a1);
        rden = 1'b1;
        inst = mk(0, a1, a0);
        tick();
        rden = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output int n, output int bad);
        n   = 0;
        bad = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
            if (rvalid) bad++;
        end
    endtask

    int n, bad, vbad, rise;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b0;
        clr   = 1'b0;
        wren  = 1'b0;
        rden  = 1'b0;
        inst  = '0;
        wdata = '0;
        tick();
        tick();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata0", {16'd0, rdata0}, 32'd0);
        chk("rst_rdata1", {16'd0, rdata1}, 32'd0);

        rst = 1'b1;
        wait_ready("sweep", n, bad);
        chk("sweep_len", n, 16);
        chk("sweep_rvalid", bad, 0);

        chk("pre_rd_rvalid", {31'd0, rvalid}, 32'd0);
        rd(0, 15);
        chk("clr_rd_rvalid", {31'd0, rvalid}, 32'd1);
        chk("clr_rd0", {16'd0, rdata0}, 32'd0);
        chk("clr_rd1", {16'd0, rdata1}, 32'd0);
        tick();
        chk("rvalid_pulse", {31'd0, rvalid}, 32'd0);

        wr(3, 16'hA5A5);
        wr(7, 16'h1234);
        rd(3, 7);
        chk("rw_rvalid", {31'd0, rvalid}, 32'd1);
        chk("rw_rd0", {16'd0, rdata0}, 32'h0000A5A5);
        chk("rw_rd1", {16'd0, rdata1}, 32'h00001234);
        rd(7, 7);
        chk("same_rd0", {16'd0, rdata0}, 32'h00001234);
        chk("same_rd1", {16'd0, rdata1}, 32'h00001234);

        wr(5, 16'h1111);
        wr(6, 16'h6666);
        wren  = 1'b1;
        rden  = 1'b1;
        wdata = 16'h2222;
        inst  = mk(5, 6, 5);
        tick();
        wren  = 1'b0;
        rden  = 1'b0;
        chk("byp_rd0", {16'd0, rdata0}, 32'h00002222);
        chk("byp_rd1", {16'd0, rdata1}, 32'h00006666);
        rd(6, 5);
        chk("byp_after0", {16'd0, rdata0}, 32'h00006666);
        chk("byp_after1", {16'd0, rdata1}, 32'h00002222);

        wr(1, 16'h0101);
        wr(2, 16'h0202);
        wr(3, 16'h0303);
        for (int i = 1; i <= 3; i++) begin
            rden = 1'b1;
            inst = mk(0, 0, i);
            tick();
            chk("b2b_rvalid", {31'd0, rvalid}, 32'd1);
            chk("b2b_rd0", {16'd0, rdata0}, 32'h0101 * i);
        end
        rden = 1'b0;
        tick();
        chk("hold_rvalid", {31'd0, rvalid}, 32'd0);
        chk("hold_rd0", {16'd0, rdata0}, 32'h00000303);
        tick();
        chk("hold2_rd0", {16'd0, rdata0}, 32'h00000303);

        for (int a = 0; a < 16; a++)
            wr(a, 16'hF000 | 16'(a + 1));
        rd(9, 15);
        chk("fill_rd0", {16'd0, rdata0}, 32'h0000F00A);
        chk("fill_rd1", {16'd0, rdata1}, 32'h0000F010);

        clr   = 1'b1;
        wren  = 1'b1;
        wdata = 16'h9999;
        inst  = mk(9, 0, 0);
        tick();
        clr = 1'b0;
        chk("clr_ready", {31'd0, ready}, 32'd0);
        vbad = 0;
        rise = 0;
        wren = 1'b1;
        rden = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wdata = 16'h5A00 | 16'(i);
            inst  = mk(i, i, i);
            if (i == 16) begin
                wren = 1'b0;
                rden = 1'b0;
            end
            if (ready) begin
                wren = 1'b0;
                rden = 1'b0;
            end
            tick();
            if (rvalid) vbad++;
            if (ready && rise == 0) rise = i;
        end
        chk("clr_len", rise, 16);
        chk("clr_rvalid", vbad, 0);
        vbad = 0;
        for (int a = 0; a < 8; a++) begin
            rd(a, a + 8);
            if (rdata0 !== 16'h0 || rdata1 !== 16'h0 || rvalid !== 1'b1)
                vbad++;
        end
        chk("clr_zero", vbad, 0);

        clr = 1'b1;
        tick();
        clr  = 1'b0;
        rden = 1'b1;
        repeat (6) tick();
        chk("mid_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        #2;
        chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("mid_rst_rd0", {16'd0, rdata0}, 32'd0);
        tick();
        rst  = 1'b1;
        rden = 1'b0;
        wait_ready("resweep", n, bad);
        chk("mid_len", n, 16);
        chk("mid_rvalid", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule
